pb_click_decoder: RTL and testbench

- Sits directly downstream of the push-button release detector. Consumes its one-cycle `released` pulse, which is already synchronized.
- Groups consecutive releases that fall within a timing window into a single click event: single, double, ... up to MAX_CLICKS.
- Presents the click count to the command/mode logic over a valid/ready handshake.
- Releases that arrive while an event is still waiting to be taken are dropped and flagged.

---
 rtl/pb_click_decoder.sv | 128 ++++++++++++
 tb/tb_pb_click_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pb_click_decoder.sv
// Groups release pulses that fall within a timing window into one click event
// (single, double, ... MAX_CLICKS) and hands the count downstream over valid/ready.
module pb_click_decoder #(
  parameter int WINDOW_CYC = 25000000,
  parameter int MAX_CLICKS = 3,
  parameter int CNT_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             released,
  input  logic             click_rdy,
  output logic             click_vld,
  output logic [CNT_W-1:0] click_num,
  output logic             busy,
  output logic             drop
);

  localparam int TW = $clog2(WINDOW_CYC);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(WINDOW_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CLICKS);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + ONE_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    num_d   = num_q;
    vld_d   = vld_q;
    drop_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (released) begin
          cnt_d   = ONE_C;
          timer_d = '0;
          if (MAX_C == ONE_C) begin
            state_d = REPORT;
            num_d   = ONE_C;
            vld_d   = 1'b1;
          end else begin
            state_d = COUNT;
          end
        end
      end

      // A release in the expiry cycle still belongs to the group and restarts the window.
      COUNT: begin
        if (released) begin
          cnt_d   = cnt_inc;
          timer_d = '0;
          if (cnt_inc == MAX_C) begin
            state_d = REPORT;
            num_d   = MAX_C;
            vld_d   = 1'b1;
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = REPORT;
          num_d   = cnt_q;
          vld_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      REPORT: begin
        drop_d = released;
        if (click_rdy) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          cnt_d   = '0;
          timer_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        cnt_d   = '0;
        timer_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      num_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      num_q   <= num_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign click_vld = vld_q;
  assign click_num = num_q;
  assign busy      = busy_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_pb_click_decoder.sv
// Scoreboard bench for pb_click_decoder with WINDOW_CYC=8, MAX_CLICKS=3:
// stimulus queues the expected click events, a monitor pops them as click_vld rises.
module tb_pb_click_decoder;

  localparam int WINDOW_CYC = 8;
  localparam int MAX_CLICKS = 3;
  localparam int CNT_W      = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             released = 1'b0;
  logic             click_rdy = 1'b0;
  logic             click_vld;
  logic [CNT_W-1:0] click_num;
  logic             busy;
  logic             drop;

  pb_click_decoder #(
    .WINDOW_CYC(WINDOW_CYC),
    .MAX_CLICKS(MAX_CLICKS),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .released (released),
    .click_rdy(click_rdy),
    .click_vld(click_vld),
    .click_num(click_num),
    .busy     (busy),
    .drop     (drop)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge following edge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int num;
    int at_edge;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   passes = 0;
  int   t0 = 0;
  logic vld_prev = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc - t0);
  endtask

  task automatic waitAfterEdge(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic at(input int n);
    waitAfterEdge(t0 + n);
  endtask

  // Drive a one-cycle release pulse sampled by edge t0+n.
  task automatic applyStimulus(input int n);
    waitAfterEdge(t0 + n - 1);
    released = 1'b1;
    waitAfterEdge(t0 + n);
    released = 1'b0;
  endtask

  task automatic expectClick(input int num, input int n);
    exp_t e;
    e.num     = num;
    e.at_edge = t0 + n;
    sb.push_back(e);
  endtask

  task automatic startTest(input logic rdy);
    @(negedge clk);
    rst_n     = 1'b0;
    released  = 1'b0;
    click_rdy = rdy;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t0    = cyc;
  endtask

  // Monitor: every rising click_vld must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      vld_prev = 1'b0;
    end else begin
      if (click_vld && !vld_prev) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_valid: got click_vld=1 num=%0d, expected no event (edge %0d)",
                   click_num, cyc - t0);
        end else begin
          cur = sb.pop_front();
          checkOutput("click_num", int'(click_num), cur.num);
          checkOutput("vld_rise_edge", cyc - t0, cur.at_edge - t0);
        end
      end else if (click_vld && vld_prev) begin
        checkOutput("num_hold", int'(click_num), cur.num);
      end
      vld_prev = click_vld;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Test 1: single click, consumer always ready
    startTest(1'b1);
    checkOutput("rst_vld",  int'(click_vld), 0);
    checkOutput("rst_num",  int'(click_num), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_drop", int'(drop), 0);
    expectClick(1, 18);
    applyStimulus(10);
    checkOutput("t1_busy10", int'(busy), 1);
    at(17);
    checkOutput("t1_vld17", int'(click_vld), 0);
    at(18);
    checkOutput("t1_busy18", int'(busy), 1);
    at(19);
    checkOutput("t1_vld19", int'(click_vld), 0);
    checkOutput("t1_busy19", int'(busy), 0);

    // Test 2: double click
    startTest(1'b1);
    applyStimulus(10);
    expectClick(2, 23);
    applyStimulus(15);
    at(22);
    checkOutput("t2_vld22", int'(click_vld), 0);
    at(24);

    // Test 3: triple click closes immediately at MAX_CLICKS
    startTest(1'b1);
    applyStimulus(10);
    applyStimulus(12);
    expectClick(3, 14);
    applyStimulus(14);
    at(15);
    checkOutput("t3_busy15", int'(busy), 0);

    // Test 4: second release in the last cycle before expiry
    startTest(1'b1);
    applyStimulus(10);
    expectClick(2, 25);
    applyStimulus(17);
    at(26);

    // Test 4b: release on the very edge where the timer would expire
    startTest(1'b1);
    applyStimulus(10);
    expectClick(2, 26);
    applyStimulus(18);
    at(25);
    checkOutput("t4b_vld25", int'(click_vld), 0);
    at(27);

    // Test 5: consumer stalls, releases during REPORT are dropped
    startTest(1'b0);
    expectClick(1, 18);
    applyStimulus(10);
    applyStimulus(20);
    checkOutput("t5_drop20", int'(drop), 1);
    checkOutput("t5_vld20", int'(click_vld), 1);
    at(21);
    checkOutput("t5_drop21", int'(drop), 0);
    at(29);
    click_rdy = 1'b1;
    applyStimulus(30);
    click_rdy = 1'b0;
    checkOutput("t5_drop30", int'(drop), 1);
    checkOutput("t5_vld30", int'(click_vld), 0);
    checkOutput("t5_busy30", int'(busy), 0);
    checkOutput("t5_num30", int'(click_num), 1);
    at(31);
    checkOutput("t5_drop31", int'(drop), 0);
    checkOutput("t5_busy31", int'(busy), 0);
    at(40);
    checkOutput("t5_busy40", int'(busy), 0);

    // Test 6: reset in the middle of a group
    startTest(1'b1);
    applyStimulus(10);
    applyStimulus(12);
    at(13);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_vld",  int'(click_vld), 0);
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_num",  int'(click_num), 0);
    checkOutput("t6_rst_drop", int'(drop), 0);
    at(16);
    rst_n = 1'b1;
    expectClick(1, 26);
    applyStimulus(18);
    checkOutput("t6_busy18", int'(busy), 1);
    at(30);

    checkOutput("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
